// File: rtl/bist_sig_ctrl.sv
// BIST controller for a BILBO register chain: seeds a MISR, compacts NPAT
// chain responses into a signature, then compares it against GOLDEN.
module bist_sig_ctrl #(
  parameter int                WIDTH  = 4,
  parameter int                NPAT   = 15,
  parameter logic [WIDTH-1:0]  POLY   = 4'b0011,
  parameter logic [WIDTH-1:0]  SEED   = 4'h0,
  parameter logic [WIDTH-1:0]  GOLDEN = 4'h9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             bilbo_b1,
  output logic             bilbo_b2,
  output logic [WIDTH-1:0] sig,
  output logic [15:0]      cnt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(NPAT - 1);

  state_t state_q, state_d;

  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SEED;
      S_SEED:  state_d = S_RUN;
      // The RUN cycle that completes compaction NPAT is the last one.
      S_RUN:   if (cnt == LAST_CNT) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Mode and status flags are decoded from the next state so they line up
  // with the registered state on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sig      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      bilbo_b1 <= 1'b1;
      bilbo_b2 <= 1'b1;
    end else begin
      state_q  <= state_d;
      bilbo_b1 <= (state_d != S_SEED);
      bilbo_b2 <= (state_d != S_RUN);
      busy     <= (state_d == S_SEED) || (state_d == S_RUN) || (state_d == S_CHECK);
      done     <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (state_d == S_SEED) pass <= 1'b0;
        end
        S_SEED: begin
          sig <= SEED;
          cnt <= '0;
        end
        S_RUN: begin
          sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data_in;
          if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
        S_CHECK: begin
          pass <= (sig == GOLDEN);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sig_ctrl.sv
// Directed bench for bist_sig_ctrl: default-parameter instance plus a
// SEED=GOLDEN=1 instance sharing the same stimulus.
module tb_bist_sig_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEED  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  data_in;

  logic        b1_0, b2_0, busy_0, done_0, pass_0;
  logic [3:0]  sig_0;
  logic [15:0] cnt_0;
  logic [2:0]  st_0;

  logic        b1_1, b2_1, busy_1, done_1, pass_1;
  logic [3:0]  sig_1;
  logic [15:0] cnt_1;
  logic [2:0]  st_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bist_sig_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .bilbo_b1(b1_0), .bilbo_b2(b2_0), .sig(sig_0), .cnt(cnt_0),
    .busy(busy_0), .done(done_0), .pass(pass_0), .state_dbg(st_0)
  );

  bist_sig_ctrl #(.SEED(4'h1), .GOLDEN(4'h1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .bilbo_b1(b1_1), .bilbo_b2(b2_1), .sig(sig_1), .cnt(cnt_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .state_dbg(st_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edge k=1 is the edge that samples start; done must first appear at k=18.
  task automatic run_once(input logic first_one, input logic hold_start,
                          input logic [3:0] exp_sig, input logic exp_pass);
    int n01 = 0;
    int n10 = 0;
    int first_done = 0;
    start   = 1'b1;
    data_in = 4'h0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if ({b1_0, b2_0} == 2'b01) n01++;
      if ({b1_0, b2_0} == 2'b10) n10++;
      if (done_0 && first_done == 0) first_done = k;
      if (k == 1 && !hold_start) start = 1'b0;
      if (k == 2) data_in = {3'b000, first_one};
      if (k == 3) begin
        data_in = 4'h0;
        check("sig_run1", 32'(sig_0), {31'd0, first_one});
        check("cnt_run1", 32'(cnt_0), 32'd1);
      end
      if (k == 17) begin
        check("sig_final", 32'(sig_0), 32'(exp_sig));
        check("cnt_final", 32'(cnt_0), 32'd15);
        check("state_check", 32'(st_0), 32'(ST_CHECK));
        check("done_early", 32'(done_0), 32'd0);
      end
    end
    check("mode01_cycles", 32'(n01), 32'd1);
    check("mode10_cycles", 32'(n10), 32'd15);
    check("done_latency", 32'(first_done), 32'd18);
    check("pass", 32'(pass_0), 32'(exp_pass));
    check("busy_done", 32'(busy_0), 32'd0);
    check("mode_done", 32'({b1_0, b2_0}), 32'd3);
  endtask

  initial begin
    int bad;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 4'h0;
    tick();
    tick();
    check("rst_state", 32'(st_0), 32'(ST_IDLE));
    check("rst_sig", 32'(sig_0), 32'd0);
    check("rst_cnt", 32'(cnt_0), 32'd0);
    check("rst_busy", 32'(busy_0), 32'd0);
    check("rst_done", 32'(done_0), 32'd0);
    check("rst_pass", 32'(pass_0), 32'd0);
    check("rst_mode", 32'({b1_0, b2_0}), 32'd3);
    check("rst_sig1", 32'(sig_1), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_start", 32'(st_0), 32'(ST_IDLE));

    // Single 1 on the first RUN cycle walks the LFSR to 4'h9.
    run_once(1'b1, 1'b0, 4'h9, 1'b1);
    tick();
    check("back_idle", 32'(st_0), 32'(ST_IDLE));
    check("idle_sig_hold", 32'(sig_0), 32'h9);
    check("idle_done", 32'(done_0), 32'd0);

    // All-zero data: dut0 stays at 0 and fails; dut1 completes the period-15 cycle.
    run_once(1'b0, 1'b0, 4'h0, 1'b0);
    check("dut1_sig", 32'(sig_1), 32'h1);
    check("dut1_pass", 32'(pass_1), 32'd1);
    check("dut1_cnt", 32'(cnt_1), 32'd15);
    check("dut1_done", 32'(done_1), 32'd1);
    tick();

    // start held through DONE must not retrigger.
    run_once(1'b1, 1'b1, 4'h9, 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (st_0 != ST_DONE || !done_0) bad++;
    end
    check("hold_no_retrigger", 32'(bad), 32'd0);
    start = 1'b0;
    tick();
    check("hold_release_idle", 32'(st_0), 32'(ST_IDLE));
    tick();
    check("hold_stay_idle", 32'(st_0), 32'(ST_IDLE));
    start = 1'b1;
    tick();
    check("rerun_seed", 32'(st_0), 32'(ST_SEED));
    check("rerun_pass_clr", 32'(pass_0), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("rerun_done", 32'(done_0), 32'd1);
    tick();

    // Reset during RUN cycle 7.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    check("mid_cnt", 32'(cnt_0), 32'd6);
    check("mid_state", 32'(st_0), 32'(ST_RUN));
    rst_n = 1'b0;
    tick();
    check("midrst_state", 32'(st_0), 32'(ST_IDLE));
    check("midrst_sig", 32'(sig_0), 32'd0);
    check("midrst_cnt", 32'(cnt_0), 32'd0);
    check("midrst_done", 32'(done_0), 32'd0);
    check("midrst_mode", 32'({b1_0, b2_0}), 32'd3);
    check("midrst_busy", 32'(busy_0), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_0 || st_0 != ST_IDLE) bad++;
    end
    check("midrst_no_done", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_sig_ctrl.md
BIST_SIG_CTRL -- requirements
Module: bist_sig_ctrl

Interface (parameters)
REQ-001 The block SHALL have parameter WIDTH, default 4: width of the register chain data and of the signature.
REQ-002 The block SHALL have parameter NPAT, default 15: number of compaction cycles per test run, legal range 1..2^16-1.
REQ-003 The block SHALL have parameter POLY, default 4'b0011: MISR feedback taps for x^4+x+1, where bit i is the tap into stage i.
REQ-004 The block SHALL have parameter SEED, default 4'h0: signature value loaded at the start of each run.
REQ-005 The block SHALL have parameter GOLDEN, default 4'h9: expected final signature.

Interface (ports)
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have port start, input, 1 bit: request a test run; level-sampled.
REQ-009 The block SHALL have port data_in, input, WIDTH bits: parallel outputs of the BILBO register chain under test.
REQ-010 The block SHALL have port bilbo_b1, output, 1 bit: BILBO mode control b1.
REQ-011 The block SHALL have port bilbo_b2, output, 1 bit: BILBO mode control b2.
REQ-012 The block SHALL have port sig, output, WIDTH bits: current MISR signature.
REQ-013 The block SHALL have port cnt, output, 16 bits: number of compaction cycles completed in the current run.
REQ-014 The block SHALL have port busy, output, 1 bit: high in the SEED, RUN and CHECK states.
REQ-015 The block SHALL have port done, output, 1 bit: high in the DONE state.
REQ-016 The block SHALL have port pass, output, 1 bit: the registered compare result, valid while done=1.

Function
REQ-017 The FSM SHALL have states IDLE, SEED, RUN, CHECK and DONE, and all outputs SHALL be registered.
REQ-018 The mode outputs SHALL be driven as b1,b2 = 1,1 in IDLE, CHECK and DONE (normal mode).
REQ-019 The mode outputs SHALL be driven as b1,b2 = 0,1 in SEED (chain scan/clear).
REQ-020 The mode outputs SHALL be driven as b1,b2 = 1,0 in RUN (chain pattern generation).
REQ-021 In IDLE, start=1 SHALL move the FSM to SEED on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-022 SEED SHALL last exactly 1 cycle, loading sig<=SEED and cnt<=0, then moving to RUN.
REQ-023 In each RUN cycle the block SHALL update sig <= ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ data_in) and cnt <= cnt+1.
REQ-024 When cnt reaches NPAT, RUN SHALL end: exactly NPAT RUN cycles, then move to CHECK.
REQ-025 CHECK SHALL last 1 cycle, registering pass <= (sig == GOLDEN); sig and cnt SHALL be held.
REQ-026 DONE SHALL hold done=1, sig, cnt and pass until start=0 is sampled, then return to IDLE; start=1 held in DONE SHALL NOT retrigger a run.
REQ-027 Latency from start sampled in IDLE to done=1 SHALL be NPAT+3 cycles.
REQ-028 start changes during SEED, RUN or CHECK SHALL be ignored; a run cannot be aborted except by reset.
REQ-029 sig SHALL retain its last value in IDLE; cnt SHALL saturate, never wrap, and is reloaded only in SEED.
REQ-030 pass SHALL be cleared to 0 on entry to SEED.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL force state=IDLE, sig=0, cnt=0, busy=0, done=0, pass=0 and bilbo_b1,b2=1,1.
REQ-032 Reset asserted mid-run (any state) SHALL take effect on that edge, with no completion and no done pulse.
REQ-033 After reset release, the block SHALL start a new run only on a sampled start=1.

Verification
REQ-034 Bench SHALL cover: defaults, start pulse, data_in=1 on the first RUN cycle then 0 -> sig=4'h1 after RUN cycle 1, sig=4'h9 after cycle 15, done at start+18 cycles, pass=1.
REQ-035 Bench SHALL cover: SEED=4'h1, GOLDEN=4'h1, data_in=0 -> LFSR period 15 returns sig=4'h1, pass=1.
REQ-036 Bench SHALL cover: defaults with data_in=0 throughout -> sig=4'h0, pass=0, cnt=15.
REQ-037 Bench SHALL cover: rst_n=0 at RUN cycle 7 -> next cycle IDLE, sig=0, cnt=0, done=0, b1,b2=1,1.
REQ-038 Bench SHALL cover: start held high through DONE -> exactly one run; a second run begins only after start falls and rises.
REQ-039 Bench SHALL cover: mode check -> b1,b2 = 0,1 for exactly 1 cycle, then 1,0 for exactly NPAT cycles, then 1,1.
